// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants for the branch predictor
//
// Purpose: 2-bit counter state encodings and default table geometry.
// Ports:   none (package).
package branch_predictor_pkg;

  localparam int IDX_W_DEFAULT = 4;

  // Counter states: strongly/weakly not-taken, weakly/strongly taken
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter next-state function
//
// Purpose: next-state logic for one BHT counter; load wins over inc, inc over dec.
// Ports:   cur      - current counter value
//          inc/dec  - step toward taken / not-taken, saturating at 3 / 0
//          load     - replace the value with load_val
//          load_val - value used on load
//          next     - resulting counter value
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (load) begin
      next = load_val;
    end else if (inc) begin
      if (cur != CTR_ST) next = cur + 2'd1;
    end else if (dec) begin
      if (cur != CTR_SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BHT + BTB branch predictor
//
// Purpose: IF-stage lookup of taken/target, EX-stage training and statistics.
// Ports:   clk, rst                 - clock, async active-high reset
//          en                       - enable; 0 predicts not-taken and freezes state
//          pc_if                    - fetch PC to look up
//          pred_bit_if              - predict taken
//          pred_target_if           - predicted target (0 unless pred_bit_if)
//          upd_valid, pc_ex         - branch resolving in EX and its PC
//          PCsrc, target_ex         - actual outcome and target
//          pred_bit_ex              - prediction that was made for that branch
//          branch_cnt, miss_cnt     - saturating resolved / mispredicted counts
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      pc_if,
  output logic             pred_bit_if,
  output logic [31:0]      pred_target_if,
  input  logic             upd_valid,
  input  logic [31:0]      pc_ex,
  input  logic             PCsrc,
  input  logic [31:0]      target_ex,
  input  logic             pred_bit_ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             valid  [DEPTH];
  logic [TAG_W-1:0] tag    [DEPTH];
  logic [1:0]       ctr    [DEPTH];
  logic [31:0]      target [DEPTH];

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             hit_if, hit_ex;
  logic [1:0]       ctr_next;
  logic             do_upd;

  // Byte offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

  assign idx_if = pc_if[IDX_W+1:2];
  assign tag_if = pc_if[31:IDX_W+2];
  assign idx_ex = pc_ex[IDX_W+1:2];
  assign tag_ex = pc_ex[31:IDX_W+2];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign hit_if         = valid[idx_if] && (tag[idx_if] == tag_if);
  assign pred_bit_if    = en && hit_if && ctr[idx_if][1];
  assign pred_target_if = pred_bit_if ? target[idx_if] : 32'h0;

  assign hit_ex = valid[idx_ex] && (tag[idx_ex] == tag_ex);
  assign do_upd = en && upd_valid;

  // On a miss the counter is loaded with the allocation value; that result is
  // only written when the miss is taken (not-taken misses do not allocate).
  sat_counter2 u_ctr (
    .cur      (ctr[idx_ex]),
    .inc      (PCsrc),
    .dec      (!PCsrc),
    .load     (!hit_ex),
    .load_val (CTR_ALLOC),
    .next     (ctr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        ctr[i]    <= CTR_RESET;
        target[i] <= 32'h0;
      end
    end else if (do_upd) begin
      if (hit_ex) begin
        ctr[idx_ex] <= ctr_next;
        if (PCsrc) target[idx_ex] <= target_ex;
      end else if (PCsrc) begin
        valid[idx_ex]  <= 1'b1;
        tag[idx_ex]    <= tag_ex;
        ctr[idx_ex]    <= ctr_next;
        target[idx_ex] <= target_ex;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (do_upd) begin
      if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
      if ((pred_bit_ex != PCsrc) && (miss_cnt != CNT_MAX)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] pc_if;
  logic        pred_bit_if;
  logic [31:0] pred_target_if;
  logic        upd_valid;
  logic [31:0] pc_ex;
  logic        PCsrc;
  logic [31:0] target_ex;
  logic        pred_bit_ex;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  logic        s_pred_bit_if;
  logic [31:0] s_pred_target_if;
  logic [1:0]  s_branch_cnt;
  logic [1:0]  s_miss_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_if(pc_if),
    .pred_bit_if(pred_bit_if), .pred_target_if(pred_target_if),
    .upd_valid(upd_valid), .pc_ex(pc_ex), .PCsrc(PCsrc),
    .target_ex(target_ex), .pred_bit_ex(pred_bit_ex),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  branch_predictor #(.IDX_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .pc_if(pc_if),
    .pred_bit_if(s_pred_bit_if), .pred_target_if(s_pred_target_if),
    .upd_valid(upd_valid), .pc_ex(pc_ex), .PCsrc(PCsrc),
    .target_ex(target_ex), .pred_bit_ex(pred_bit_ex),
    .branch_cnt(s_branch_cnt), .miss_cnt(s_miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic pred);
    upd_valid   = 1'b1;
    pc_ex       = pc;
    PCsrc       = taken;
    target_ex   = tgt;
    pred_bit_ex = pred;
    tick();
    upd_valid   = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_bit,
                      input logic [31:0] exp_tgt);
    pc_if = pc;
    #1;
    check({tag, "_bit"}, {31'h0, pred_bit_if}, {31'h0, exp_bit});
    check({tag, "_tgt"}, pred_target_if, exp_tgt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pc_if = 32'h40; upd_valid = 1'b0;
    pc_ex = 32'h0; PCsrc = 1'b0; target_ex = 32'h0; pred_bit_ex = 1'b0;
    tick(); tick();
    rst = 1'b0;
    look("reset", 32'h40, 1'b0, 32'h0);
    check("reset_branch", {16'h0, branch_cnt}, 32'd0);
    check("reset_miss", {16'h0, miss_cnt}, 32'd0);

    // Allocate 0x40 -> ctr WT
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("alloc", 32'h40, 1'b1, 32'h100);
    check("alloc_branch", {16'h0, branch_cnt}, 32'd1);
    check("alloc_miss", {16'h0, miss_cnt}, 32'd1);

    // Two taken: 10->11->11
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("st", 32'h40, 1'b1, 32'h100);
    // Not-taken: 11->10
    upd(32'h40, 1'b0, 32'h999, 1'b1);
    look("nt1", 32'h40, 1'b1, 32'h100);
    // 10->01
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look("nt2", 32'h40, 1'b0, 32'h0);
    // 01->00, predicted correctly
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("nt3", 32'h40, 1'b0, 32'h0);
    check("nt_branch", {16'h0, branch_cnt}, 32'd6);
    check("nt_miss", {16'h0, miss_cnt}, 32'd3);

    // 00->01 (still not-taken), 01->10 with new target
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    look("t_from_snt", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    look("t_to_wt", 32'h40, 1'b1, 32'h104);
    check("t_miss", {16'h0, miss_cnt}, 32'd5);

    // Aliasing: 0x440 shares index 0 with 0x40
    upd(32'h440, 1'b1, 32'h200, 1'b0);
    look("alias_old", 32'h40, 1'b0, 32'h0);
    look("alias_new", 32'h440, 1'b1, 32'h200);
    upd(32'h840, 1'b0, 32'h300, 1'b0);
    look("nt_miss_keep", 32'h440, 1'b1, 32'h200);
    look("nt_miss_noalloc", 32'h840, 1'b0, 32'h0);
    check("alias_branch", {16'h0, branch_cnt}, 32'd10);
    check("alias_miss", {16'h0, miss_cnt}, 32'd6);

    // Same-cycle read/write: lookup sees pre-update value
    pc_if = 32'h440;
    upd_valid = 1'b1; pc_ex = 32'h440; PCsrc = 1'b0; target_ex = 32'h0; pred_bit_ex = 1'b1;
    #1;
    check("rw_before", {31'h0, pred_bit_if}, 32'd1);
    tick();
    upd_valid = 1'b0;
    check("rw_after", {31'h0, pred_bit_if}, 32'd0);
    check("rw_miss", {16'h0, miss_cnt}, 32'd7);

    // en=0 freezes everything
    upd(32'h44, 1'b1, 32'h300, 1'b0);
    look("en_pre", 32'h44, 1'b1, 32'h300);
    en = 1'b0;
    look("en0_pred", 32'h44, 1'b0, 32'h0);
    upd(32'h48, 1'b1, 32'h400, 1'b0);
    check("en0_branch", {16'h0, branch_cnt}, 32'd12);
    check("en0_miss", {16'h0, miss_cnt}, 32'd8);
    en = 1'b1;
    look("en1_restore", 32'h44, 1'b1, 32'h300);
    look("en1_noalloc", 32'h48, 1'b0, 32'h0);

    // Async reset between edges with an update pending
    pc_if = 32'h44;
    upd_valid = 1'b1; pc_ex = 32'h44; PCsrc = 1'b1; target_ex = 32'h500; pred_bit_ex = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_bit", {31'h0, pred_bit_if}, 32'd0);
    check("arst_tgt", pred_target_if, 32'h0);
    check("arst_branch", {16'h0, branch_cnt}, 32'd0);
    check("arst_miss", {16'h0, miss_cnt}, 32'd0);
    tick();
    upd_valid = 1'b0;
    rst = 1'b0;
    look("arst_inval", 32'h44, 1'b0, 32'h0);
    look("arst_inval2", 32'h440, 1'b0, 32'h0);

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) upd(32'h4C, 1'b0, 32'h0, 1'b1);
    check("cnt_branch", {16'h0, branch_cnt}, 32'd5);
    check("cnt_miss", {16'h0, miss_cnt}, 32'd5);
    check("sat_branch", {30'h0, s_branch_cnt}, 32'd3);
    check("sat_miss", {30'h0, s_miss_cnt}, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch predictor for the 5-stage pipeline: a direct-mapped branch history table (BHT) of 2-bit saturating counters plus a branch target buffer (BTB).
- In IF it looks up the fetch PC and produces pred_bit_if and pred_target_if. pred_bit_if travels down the pipe and reaches EX as pred_bit_ex.
- In EX it is trained with the resolved outcome (PCsrc, target_ex) and keeps branch/mispredict statistics.
- It is the producer side of the EX misprediction comparator.

Parameters:
- IDX_W, 4, index bits; table depth = 2**IDX_W entries.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  predictor enable; 0 = predict not-taken and freeze tables and statistics.
- pc_if  input  32  fetch-stage PC.
- pred_bit_if  output  1  1 = predict taken.
- pred_target_if  output  32  predicted target; valid only when pred_bit_if=1.
- upd_valid  input  1  a conditional branch is resolving in EX this cycle.
- pc_ex  input  32  PC of the resolving branch.
- PCsrc  input  1  actual outcome, 1 = taken.
- target_ex  input  32  actual branch target.
- pred_bit_ex  input  1  prediction that was made for the EX branch.
- branch_cnt  output  CNT_W  resolved-branch count.
- miss_cnt  output  CNT_W  mispredicted-branch count.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Address fields:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2], TAG_W = 30-IDX_W
  - pc[1:0] ignored.
- Per-entry state: valid (1), tag (TAG_W), ctr (2), target (32).
- Reset (async, at any time including mid-update):
  - all valid=0, all ctr=2'b01 (weakly not-taken), all target=0, all tag=0.
  - branch_cnt=0, miss_cnt=0.
  - Outputs follow immediately: pred_bit_if=0, pred_target_if=0.
- Lookup (combinational, zero latency from pc_if):
  - hit_if = valid[idx] && tag[idx]==tag(pc_if).
  - pred_bit_if = en && hit_if && ctr[idx][1].
  - pred_target_if = pred_bit_if ? target[idx] : 32'h0.
- Update at posedge clk when en && upd_valid; idx/tag taken from pc_ex:
  - Hit, PCsrc=1: ctr = min(ctr+1, 3); target = target_ex.
  - Hit, PCsrc=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss, PCsrc=1: allocate/replace the entry: valid=1, tag=tag(pc_ex), ctr=2'b10 (weakly taken), target=target_ex.
  - Miss, PCsrc=0: no table change (no allocation).
- Statistics at posedge when en && upd_valid:
  - branch_cnt += 1.
  - miss_cnt += 1 if pred_bit_ex != PCsrc.
  - Both saturate at all-ones (no wrap).
- Same-cycle read/write of the same index: lookup returns the pre-update value (no bypass); the new value is visible the next cycle.
- en=0: no table or statistics change regardless of upd_valid; pred_bit_if=0.
- upd_valid=0: tables and counters hold.
- Counter state machine per entry: SNT(00) ↔ WNT(01) ↔ WT(10) ↔ ST(11).
  - Taken moves right, not-taken moves left.
  - Saturates at both ends.
  - Predict taken in WT/ST.

Decomposition:
- Shared package: constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST, CTR_RESET=CTR_WNT, CTR_ALLOC=CTR_WT; the IDX_W default.
- One sub-module: sat_counter2 (2-bit saturating up/down counter, inc/dec/load inputs), instantiated per entry or used as a next-state function.
- Tables, tag compare and statistics stay in branch_predictor.

Test Plan:
- Reset then pc_if=0x40, en=1 -> pred_bit_if=0, pred_target_if=0, branch_cnt=0, miss_cnt=0.
- Update pc_ex=0x40, PCsrc=1, target_ex=0x100, pred_bit_ex=0 -> next cycle, pc_if=0x40 gives pred_bit_if=1 and pred_target_if=0x100; branch_cnt=1, miss_cnt=1.
- Same branch: two further taken updates, then 3 not-taken updates (ctr 10→11→11→10→01→00):
  - pred_bit_if=1 after the first not-taken;
  - pred_bit_if=0 after the second and third;
  - miss_cnt counts only cycles where pred_bit_ex != PCsrc.
- Aliasing: entry for 0x40 present; taken update at pc_ex=0x440 (same index, different tag, IDX_W=4) -> lookup 0x40 gives pred_bit_if=0, lookup 0x440 gives pred_bit_if=1; a not-taken miss at 0x840 leaves the 0x440 entry intact.
- en=0 with upd_valid=1, PCsrc=1 -> no table change, counters hold, pred_bit_if=0; re-enabling restores prior predictions.
- Assert rst mid-stream, between clock edges, with upd_valid=1 -> outputs zero immediately, all entries invalid; statistics saturation check via CNT_W=2: 5 updates -> branch_cnt=3.
